cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Execution side of the 8-bit CPU: consumes the 12-bit control word from the sequencer each
//  cycle and implements PC, MAR, RAM, IR, A, B, adder/subtractor and the shared 8-bit bus.
//  Returns the current opcode to the sequencer and latches halt. Sits between the sequencer
//  and the display/debug logic.
// PARAMETERS
//  ADDR_W   4   address width; PC, MAR and the IR operand field are ADDR_W bits
//  DATA_W   8   bus/register/memory word width; opcode = ir[DATA_W-1 -: 4]
//  DEPTH    16  RAM words (2**ADDR_W)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       reset, asynchronous, active-high
//  ctrl         in   12      control word: [11]HLT [10]PC_INC [9]PC_EN [8]MAR_LOAD [7]MEM_EN [6]IR_LOAD
//                            [5]IR_EN [4]A_LOAD [3]A_EN [2]B_LOAD [1]ADDER_SUB [0]ADDER_EN
//  prog_we      in   1       program-load write strobe
//  prog_addr    in   ADDR_W  program-load address
//  prog_data    in   DATA_W  program-load data
//  opcode       out  4       ir[7:4], to sequencer
//  a_out        out  DATA_W  A register contents
//  bus_out      out  DATA_W  current bus value (combinational, debug)
//  flag_c       out  1       carry / no-borrow from last adder write to A
//  flag_z       out  1       zero from last adder write to A
//  halted       out  1       sticky halt
//  bus_conflict out  1       sticky: more than one bus driver seen at a clock edge
// BEHAVIOUR
//  - Reset: pc, mar, ir, a, b = 0; flag_c, flag_z, halted, bus_conflict = 0. RAM not reset.
//  - Bus (combinational): driver priority PC_EN > MEM_EN > IR_EN > A_EN > ADDER_EN;
//    PC_EN -> {0,pc}; MEM_EN -> ram[mar]; IR_EN -> {0,ir[3:0]}; A_EN -> a; ADDER_EN -> sum.
//    No driver -> bus = 0. Two or more enables at an edge (not halted) set bus_conflict.
//  - Adder (combinational): sum = a + (ADDER_SUB ? ~b + 1 : b), modulo 2**DATA_W.
//    carry = bit DATA_W of the (DATA_W+1)-bit sum; for SUB, carry=1 means a >= b (no borrow).
//  - Rising edge, when not halted, all loads in parallel from the pre-edge bus:
//    MAR_LOAD: mar <= bus[ADDR_W-1:0]; IR_LOAD: ir <= bus; A_LOAD: a <= bus; B_LOAD: b <= bus;
//    PC_INC: pc <= pc + 1, wraps 15 -> 0. PC_EN with PC_INC: bus carries the pre-increment pc.
//    A_EN with A_LOAD: a unchanged. ADDER_EN with A_LOAD: flag_c <= carry, flag_z <= (sum==0);
//    otherwise flags hold.
//  - HLT sampled at an edge sets halted; the other bits of that word are still applied on
//    that edge. While halted, pc/mar/ir/a/b/flags/bus_conflict freeze; only rst clears halted.
//  - RAM: asynchronous read at mar; synchronous write ram[prog_addr] <= prog_data on prog_we,
//    accepted in any state. Write and MEM_EN read at the same address in one cycle: bus shows
//    the old word, the new word is visible from the next cycle.
//  - Latency: a value loaded at edge N is visible on opcode/a_out/bus from edge N onward.
//  - rst mid-instruction: immediate return to reset values, RAM contents kept.
// STRUCTURE
//  - Shared package cpu_pkg: CTRL_W=12, control bit index constants (HLT..ADDER_EN),
//    opcode constants (LDA=0, ADD=1, SUB=2, HLT=15); shared with the sequencer.
//  - One sub-module: cpu_alu (a, b, sub -> sum, carry, zero), combinational.
//  - Registers, RAM array and bus mux stay in cpu_datapath.
// TESTING
//  1 Reset: rst pulse mid-run -> pc=mar=ir=a=b=0, halted=0, bus_out=0 with ctrl=0.
//  2 Program load ram[0]=8'h0E, ram[14]=8'h1C; fetch/LDA ctrl sequence -> opcode=0, a_out=8'h1C, pc=1.
//  3 ADD: a=8'hF0, ram[15]=8'h20, ADD 15 sequence -> a_out=8'h10, flag_c=1, flag_z=0.
//  4 SUB: a=8'h05, b loaded 8'h05, ADDER_SUB|ADDER_EN|A_LOAD -> a_out=0, flag_z=1, flag_c=1;
//    a=8'h03, b=8'h05 -> a_out=8'hFE, flag_c=0.
//  5 PC wrap: pc=15, PC_INC -> pc=0; PC_EN|PC_INC same cycle -> bus_out=8'h0F, pc then 0.
//  6 Halt/conflict: ctrl=PC_EN|MEM_EN -> bus=pc, bus_conflict=1; HLT then PC_INC|A_LOAD ->
//    halted=1, pc and a unchanged until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word layout and opcode encodings,
// common to the sequencer and the datapath.
package cpu_pkg;

   localparam int unsigned CTRL_W = 12;

   localparam int unsigned CTL_HLT       = 11;
   localparam int unsigned CTL_PC_INC    = 10;
   localparam int unsigned CTL_PC_EN     = 9;
   localparam int unsigned CTL_MAR_LOAD  = 8;
   localparam int unsigned CTL_MEM_EN    = 7;
   localparam int unsigned CTL_IR_LOAD   = 6;
   localparam int unsigned CTL_IR_EN     = 5;
   localparam int unsigned CTL_A_LOAD    = 4;
   localparam int unsigned CTL_A_EN      = 3;
   localparam int unsigned CTL_B_LOAD    = 2;
   localparam int unsigned CTL_ADDER_SUB = 1;
   localparam int unsigned CTL_ADDER_EN  = 0;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_HLT = 4'hF
   } opcode_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Sequencer/loader <-> datapath signal bundle; master drives control and
// program-load, slave is the datapath.
interface cpu_datapath_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   import cpu_pkg::*;

   logic [CTRL_W-1:0] ctrl;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [3:0]        opcode;
   logic [DATA_W-1:0] a_out;
   logic [DATA_W-1:0] bus_out;
   logic              flag_c;
   logic              flag_z;
   logic              halted;
   logic              bus_conflict;

   modport master (
      output ctrl, prog_we, prog_addr, prog_data,
      input  opcode, a_out, bus_out, flag_c, flag_z, halted, bus_conflict
   );

   modport slave (
      input  ctrl, prog_we, prog_addr, prog_data,
      output opcode, a_out, bus_out, flag_c, flag_z, halted, bus_conflict
   );
endinterface

// File: rtl/cpu_alu.sv
// Combinational adder/subtractor; for subtraction carry=1 means a >= b.
module cpu_alu #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] sum,
   output logic              carry,
   output logic              zero
);
   logic [DATA_W-1:0] b_opnd;

   always_comb begin
      b_opnd       = sub ? ~b : b;
      {carry, sum} = {1'b0, a} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, sub};
      zero         = (sum == '0);
   end
endmodule

// File: rtl/cpu_datapath.sv
// Execution side of the 8-bit CPU: PC, MAR, RAM, IR, A, B, ALU and the
// shared bus, driven by one control word per cycle.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input logic          clk,
   input logic          rst,
   cpu_datapath_if.slave dp
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              flag_c;
   logic              flag_z;
   logic              halted;
   logic              bus_conflict;
   logic [DATA_W-1:0] ram [DEPTH];

   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] sum;
   logic              carry;
   logic              zero;
   logic              multi_drv;
   logic [CTRL_W-1:0] c;

   assign c = dp.ctrl;

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .a     (a),
      .b     (b),
      .sub   (c[CTL_ADDER_SUB]),
      .sum   (sum),
      .carry (carry),
      .zero  (zero)
   );

   always_comb begin
      bus = '0;
      if (c[CTL_PC_EN])         bus = DATA_W'(pc);
      else if (c[CTL_MEM_EN])   bus = ram[mar];
      else if (c[CTL_IR_EN])    bus = DATA_W'(ir[ADDR_W-1:0]);
      else if (c[CTL_A_EN])     bus = a;
      else if (c[CTL_ADDER_EN]) bus = sum;
      multi_drv = $countones({c[CTL_PC_EN], c[CTL_MEM_EN], c[CTL_IR_EN],
                              c[CTL_A_EN], c[CTL_ADDER_EN]}) > 1;
   end

   // Program-load port is independent of halt and reset.
   always_ff @(posedge clk) begin
      if (dp.prog_we) ram[dp.prog_addr] <= dp.prog_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= '0;
         mar          <= '0;
         ir           <= '0;
         a            <= '0;
         b            <= '0;
         flag_c       <= 1'b0;
         flag_z       <= 1'b0;
         halted       <= 1'b0;
         bus_conflict <= 1'b0;
      end else if (!halted) begin
         if (c[CTL_HLT])      halted <= 1'b1;
         if (multi_drv)       bus_conflict <= 1'b1;
         if (c[CTL_PC_INC])   pc <= pc + 1'b1;
         if (c[CTL_MAR_LOAD]) mar <= bus[ADDR_W-1:0];
         if (c[CTL_IR_LOAD])  ir <= bus;
         if (c[CTL_B_LOAD])   b <= bus;
         // A driving the bus into itself is a no-op even if a higher-priority source wins.
         if (c[CTL_A_LOAD] && !c[CTL_A_EN]) a <= bus;
         if (c[CTL_A_LOAD] && c[CTL_ADDER_EN]) begin
            flag_c <= carry;
            flag_z <= zero;
         end
      end
   end

   assign dp.opcode       = ir[DATA_W-1 -: 4];
   assign dp.a_out        = a;
   assign dp.bus_out      = bus;
   assign dp.flag_c       = flag_c;
   assign dp.flag_z       = flag_z;
   assign dp.halted       = halted;
   assign dp.bus_conflict = bus_conflict;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: stimulus queues expected values, a
// negedge monitor pops and compares them against the outputs.
module tb_cpu_datapath;
   localparam logic [11:0] HLT = 12'h800, PC_INC = 12'h400, PC_EN = 12'h200,
                           MAR_LOAD = 12'h100, MEM_EN = 12'h080, IR_LOAD = 12'h040,
                           IR_EN = 12'h020, A_LOAD = 12'h010, A_EN = 12'h008,
                           B_LOAD = 12'h004, ADDER_SUB = 12'h002, ADDER_EN = 12'h001;

   typedef enum int {F_OPC, F_A, F_BUS, F_C, F_Z, F_HALT, F_CONF} field_e;
   typedef struct {
      string      name;
      field_e     f;
      logic [7:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   exp_t e;
   logic [7:0] act;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   cpu_datapath_if #(.ADDR_W(4), .DATA_W(8)) dif ();

   cpu_datapath #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .dp  (dif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   function automatic logic [7:0] sample(field_e f);
      case (f)
         F_OPC:   return {4'h0, dif.opcode};
         F_A:     return dif.a_out;
         F_BUS:   return dif.bus_out;
         F_C:     return {7'h0, dif.flag_c};
         F_Z:     return {7'h0, dif.flag_z};
         F_HALT:  return {7'h0, dif.halted};
         default: return {7'h0, dif.bus_conflict};
      endcase
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         act = sample(e.f);
         n_vec++;
         if (act !== e.v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", e.name, act, e.v);
         end
      end
   end

   task automatic expect_val(input string n, input field_e f, input logic [7:0] v);
      exp_t x;
      x.name = n;
      x.f    = f;
      x.v    = v;
      sb.push_back(x);
   endtask

   // Apply a control word for one cycle; bus expectations must be queued before tick.
   task automatic drive(input logic [11:0] w);
      dif.ctrl = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      dif.ctrl    = '0;
      dif.prog_we = 1'b0;
   endtask

   task automatic load(input logic [3:0] ad, input logic [7:0] d);
      dif.prog_we   = 1'b1;
      dif.prog_addr = ad;
      dif.prog_data = d;
      tick();
   endtask

   task automatic fetch(input logic [7:0] word);
      drive(PC_EN | MAR_LOAD);                  tick();
      drive(PC_INC | MEM_EN | IR_LOAD);
      expect_val("fetch_bus", F_BUS, word);     tick();
      drive(IR_EN | MAR_LOAD);
      expect_val("operand_bus", F_BUS, {4'h0, word[3:0]}); tick();
   endtask

   initial begin
      dif.ctrl      = '0;
      dif.prog_we   = 1'b0;
      dif.prog_addr = '0;
      dif.prog_data = '0;
      #12 rst = 1'b0;
      @(posedge clk); #1;

      expect_val("rst_a", F_A, 8'h00);
      expect_val("rst_opc", F_OPC, 8'h00);
      expect_val("rst_bus", F_BUS, 8'h00);
      expect_val("rst_halt", F_HALT, 8'h00);
      expect_val("rst_conf", F_CONF, 8'h00);
      tick();

      load(4'd0, 8'h0E); load(4'd14, 8'h1C);
      load(4'd1, 8'h0D); load(4'd13, 8'hF0);
      load(4'd2, 8'h1F); load(4'd15, 8'h20);

      // LDA 14
      fetch(8'h0E);
      drive(MEM_EN | A_LOAD);
      expect_val("lda_bus", F_BUS, 8'h1C);      tick();
      expect_val("lda_a", F_A, 8'h1C);
      expect_val("lda_opc", F_OPC, 8'h00);
      drive(PC_EN);
      expect_val("lda_pc", F_BUS, 8'h01);       tick();

      // LDA 13 then ADD 15
      fetch(8'h0D);
      drive(MEM_EN | A_LOAD);                   tick();
      expect_val("lda2_a", F_A, 8'hF0);
      fetch(8'h1F);
      expect_val("add_opc", F_OPC, 8'h01);
      drive(MEM_EN | B_LOAD);
      expect_val("add_b_bus", F_BUS, 8'h20);    tick();
      drive(ADDER_EN | A_LOAD);
      expect_val("add_sum_bus", F_BUS, 8'h10);  tick();
      expect_val("add_a", F_A, 8'h10);
      expect_val("add_c", F_C, 8'h01);
      expect_val("add_z", F_Z, 8'h00);
      tick();

      // asynchronous reset mid-run, RAM retained
      #2 rst = 1'b1;
      expect_val("midrst_a", F_A, 8'h00);
      expect_val("midrst_opc", F_OPC, 8'h00);
      expect_val("midrst_c", F_C, 8'h00);
      @(negedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      drive(PC_EN);
      expect_val("midrst_pc", F_BUS, 8'h00);    tick();
      drive(MEM_EN);
      expect_val("midrst_mar_ram", F_BUS, 8'h0E); tick();
      drive(IR_EN);
      expect_val("midrst_ir", F_BUS, 8'h00);    tick();

      // SUB with equal operands, then with borrow
      load(4'd0, 8'h05);
      drive(MEM_EN | A_LOAD);                   tick();
      drive(MEM_EN | B_LOAD);                   tick();
      drive(ADDER_SUB | ADDER_EN | A_LOAD);
      expect_val("sub0_bus", F_BUS, 8'h00);     tick();
      expect_val("sub0_a", F_A, 8'h00);
      expect_val("sub0_z", F_Z, 8'h01);
      expect_val("sub0_c", F_C, 8'h01);
      dif.prog_we = 1'b1; dif.prog_addr = 4'd0; dif.prog_data = 8'h03;
      drive(MEM_EN);
      expect_val("wr_rd_old", F_BUS, 8'h05);    tick();
      drive(MEM_EN | A_LOAD);
      expect_val("wr_rd_new", F_BUS, 8'h03);    tick();
      expect_val("a_3", F_A, 8'h03);
      expect_val("flags_hold_z", F_Z, 8'h01);
      drive(ADDER_SUB | ADDER_EN | A_LOAD);     tick();
      expect_val("sub1_a", F_A, 8'hFE);
      expect_val("sub1_c", F_C, 8'h00);
      expect_val("sub1_z", F_Z, 8'h00);
      drive(A_EN | A_LOAD);
      expect_val("a_self_bus", F_BUS, 8'hFE);   tick();
      expect_val("a_self_a", F_A, 8'hFE);

      // PC wrap
      for (int i = 0; i < 15; i++) begin
         drive(PC_INC); tick();
      end
      drive(PC_EN);
      expect_val("pc_15", F_BUS, 8'h0F);        tick();
      drive(PC_EN | PC_INC);
      expect_val("pc_inc_bus", F_BUS, 8'h0F);   tick();
      drive(PC_EN);
      expect_val("pc_wrap", F_BUS, 8'h00);      tick();

      // conflict and halt
      drive(PC_INC);                            tick();
      expect_val("conf_pre", F_CONF, 8'h00);
      drive(PC_EN | MEM_EN);
      expect_val("conf_bus", F_BUS, 8'h01);     tick();
      expect_val("conf_set", F_CONF, 8'h01);
      drive(HLT | PC_INC);                      tick();
      expect_val("halt_set", F_HALT, 8'h01);
      drive(PC_EN | PC_INC | A_LOAD);
      expect_val("halt_pc_bus", F_BUS, 8'h02);  tick();
      expect_val("halt_a", F_A, 8'hFE);
      drive(PC_EN);
      expect_val("halt_pc_frozen", F_BUS, 8'h02); tick();
      dif.prog_we = 1'b1; dif.prog_addr = 4'd0; dif.prog_data = 8'h77;
      tick();
      drive(MEM_EN);
      expect_val("halt_prog_write", F_BUS, 8'h77); tick();
      #2 rst = 1'b1;
      expect_val("unhalt", F_HALT, 8'h00);
      expect_val("unconf", F_CONF, 8'h00);
      expect_val("unhalt_a", F_A, 8'h00);
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk); #1;

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
